// File: rtl/pixel_rpc_pkg.sv
// rtl/pixel_rpc_pkg.sv - shared types and defaults for the two-client setget_pixel RPC arbiter
package pixel_rpc_pkg;

    localparam int XW_DEF = 32;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SREQ  = 2'd1,
        SDROP = 2'd2,
        CACK  = 2'd3
    } state_t;

endpackage

// File: rtl/rpc_rr_pick2.sv
// rtl/rpc_rr_pick2.sv - combinational two-way round-robin picker
// Ports: elig[1:0] per-client eligibility, last = client served most recently,
//        grant_valid = some client eligible, sel = chosen client.
module rpc_rr_pick2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic       grant_valid,
    output logic       sel
);

    always_comb begin
        grant_valid = |elig;
        sel         = 1'b0;
        case (elig)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            // Tie: favour the client that was not served last.
            2'b11:   sel = ~last;
            default: sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/pixel_rpc_arbiter.sv
// rtl/pixel_rpc_arbiter.sv - serialises two setget_pixel RPC clients onto one pixel server
// Ports: clk, reset (async, active low);
//        c0_*/c1_*: client req/x/y/readf/wdata in, ack/return out;
//        s_*: server req/x/y/readf/wdata out, ack/return in; busy = not IDLE.
module pixel_rpc_arbiter
    import pixel_rpc_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c0_req,
    input  logic [XW-1:0] c0_x,
    input  logic [XW-1:0] c0_y,
    input  logic          c0_readf,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_ack,
    output logic [DW-1:0] c0_return,
    input  logic          c1_req,
    input  logic [XW-1:0] c1_x,
    input  logic [XW-1:0] c1_y,
    input  logic          c1_readf,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_ack,
    output logic [DW-1:0] c1_return,
    output logic          s_req,
    output logic [XW-1:0] s_x,
    output logic [XW-1:0] s_y,
    output logic          s_readf,
    output logic [DW-1:0] s_wdata,
    input  logic          s_ack,
    input  logic [DW-1:0] s_return,
    output logic          busy
);

    state_t        state;
    logic          last;
    logic          sel;
    logic [DW-1:0] ret;

    logic [1:0]    elig;
    logic          pick_valid;
    logic          pick_sel;
    logic          sel_req;

    // A client whose ack is still high has already been served for this
    // request; it only becomes eligible again after the full handshake.
    assign elig    = {c1_req & ~c1_ack, c0_req & ~c0_ack};
    assign sel_req = sel ? c1_req : c0_req;

    rpc_rr_pick2 u_pick (
        .elig        (elig),
        .last        (last),
        .grant_valid (pick_valid),
        .sel         (pick_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            ret       <= '0;
            s_req     <= 1'b0;
            s_x       <= '0;
            s_y       <= '0;
            s_readf   <= 1'b0;
            s_wdata   <= '0;
            c0_ack    <= 1'b0;
            c1_ack    <= 1'b0;
            c0_return <= '0;
            c1_return <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel     <= pick_sel;
                        s_x     <= pick_sel ? c1_x     : c0_x;
                        s_y     <= pick_sel ? c1_y     : c0_y;
                        s_readf <= pick_sel ? c1_readf : c0_readf;
                        s_wdata <= pick_sel ? c1_wdata : c0_wdata;
                        s_req   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SREQ;
                    end
                end
                SREQ: begin
                    if (s_ack) begin
                        ret   <= s_return;
                        s_req <= 1'b0;
                        state <= SDROP;
                    end
                end
                SDROP: begin
                    // Only answer the client once the server link is fully
                    // back at rest, so a new grant never overlaps its ack.
                    if (!s_ack) begin
                        if (sel) begin
                            c1_ack    <= 1'b1;
                            c1_return <= ret;
                        end else begin
                            c0_ack    <= 1'b1;
                            c0_return <= ret;
                        end
                        state <= CACK;
                    end
                end
                CACK: begin
                    if (!sel_req) begin
                        c0_ack <= 1'b0;
                        c1_ack <= 1'b0;
                        last   <= sel;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_rpc_arbiter.sv
// tb/tb_pixel_rpc_arbiter.sv - directed self-checking bench for pixel_rpc_arbiter
module tb_pixel_rpc_arbiter;

    localparam int XW = 32;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c0_req, c1_req;
    logic [XW-1:0] x0, y0, x1, y1;
    logic          rd0, rd1;
    logic [DW-1:0] wd0, wd1;
    logic          c0_ack, c1_ack;
    logic [DW-1:0] c0_return, c1_return;
    logic          s_req;
    logic [XW-1:0] s_x, s_y;
    logic          s_readf;
    logic [DW-1:0] s_wdata;
    logic          s_ack;
    logic [DW-1:0] s_return;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Client model: keeps req up while it still owes transactions and drops
    // it as soon as its ack is seen (a zero-wait client).
    int rem0 = 0;
    int rem1 = 0;
    assign c0_req = (rem0 > 0) & ~c0_ack;
    assign c1_req = (rem1 > 0) & ~c1_ack;

    // Server model: responds after srv_wait falling edges (2 behaves like a
    // registered server answering on the next clock), in both phases.
    int            srv_wait = 2;
    logic [DW-1:0] srv_ret  = '0;
    int            scnt     = 0;

    // Monitor state.
    int            cyc = 0;
    int            rise_q[$];
    logic [XW-1:0] rise_x[$];
    int            order[$];
    logic [XW-1:0] hold_x;
    int            unstable = 0;
    int            sack_fall_cyc = 0;
    int            ack0_rise_cyc = 0;
    int            c1_req_fall_cyc = 0;
    int            busy_fall_cyc = 0;
    logic          c1_ack_seen = 1'b0;
    logic [DW-1:0] ret0, ret1;
    logic [XW-1:0] cap_x, cap_y;
    logic          cap_rd;
    logic [DW-1:0] cap_wd;
    logic          p_sreq = 1'b0, p_c0ack = 1'b0, p_c1ack = 1'b0;
    logic          p_c1req = 1'b0, p_busy = 1'b0;

    pixel_rpc_arbiter #(.XW(XW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .c0_req    (c0_req),
        .c0_x      (x0),
        .c0_y      (y0),
        .c0_readf  (rd0),
        .c0_wdata  (wd0),
        .c0_ack    (c0_ack),
        .c0_return (c0_return),
        .c1_req    (c1_req),
        .c1_x      (x1),
        .c1_y      (y1),
        .c1_readf  (rd1),
        .c1_wdata  (wd1),
        .c1_ack    (c1_ack),
        .c1_return (c1_return),
        .s_req     (s_req),
        .s_x       (s_x),
        .s_y       (s_y),
        .s_readf   (s_readf),
        .s_wdata   (s_wdata),
        .s_ack     (s_ack),
        .s_return  (s_return),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor then server, both on the falling edge, in a fixed order.
    initial begin
        s_ack    = 1'b0;
        s_return = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (s_req && !p_sreq) begin
                rise_q.push_back(cyc);
                rise_x.push_back(s_x);
                hold_x = s_x;
            end
            if (s_req && s_x !== hold_x) unstable++;
            if (c0_ack && !p_c0ack) begin
                order.push_back(0);
                ack0_rise_cyc = cyc;
                ret0 = c0_return;
                if (rem0 > 0) rem0--;
            end
            if (c1_ack && !p_c1ack) begin
                order.push_back(1);
                ret1 = c1_return;
                if (rem1 > 0) rem1--;
            end
            if (c1_ack) c1_ack_seen = 1'b1;
            if (!c1_req && p_c1req) c1_req_fall_cyc = cyc;
            if (!busy && p_busy) busy_fall_cyc = cyc;
            p_sreq  = s_req;
            p_c0ack = c0_ack;
            p_c1ack = c1_ack;
            p_c1req = c1_req;
            p_busy  = busy;

            if (!reset) begin
                s_ack = 1'b0;
                scnt  = 0;
            end else if (s_req && !s_ack) begin
                scnt++;
                if (scnt >= srv_wait) begin
                    s_ack    = 1'b1;
                    s_return = srv_ret;
                    cap_x    = s_x;
                    cap_y    = s_y;
                    cap_rd   = s_readf;
                    cap_wd   = s_wdata;
                    scnt     = 0;
                end
            end else if (!s_req && s_ack) begin
                scnt++;
                if (scnt >= srv_wait) begin
                    s_ack         = 1'b0;
                    sack_fall_cyc = cyc;
                    scnt          = 0;
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(rem0 == 0 && rem1 == 0 && !busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int alt_err;
        int n;
        reset = 1'b0;
        x0 = '0; y0 = '0; rd0 = 1'b0; wd0 = '0;
        x1 = '0; y1 = '0; rd1 = 1'b0; wd1 = '0;
        repeat (2) @(negedge clk);
        check("rst_s_req", 32'(s_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({c0_ack, c1_ack}), 32'd0);
        check("rst_s_x", s_x, 32'd0);
        check("rst_wdata", 32'(s_wdata), 32'd0);
        check("rst_c0_ret", 32'(c0_return), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single write from c0, server answers after a 3-edge wait.
        x0 = 32'd3; y0 = 32'd5; rd0 = 1'b0; wd0 = 8'h7F;
        srv_wait = 3; srv_ret = 8'h7F; c1_ack_seen = 1'b0;
        rem0 = 1;
        wait_done("wr_done");
        check("wr_s_x", cap_x, 32'd3);
        check("wr_s_y", cap_y, 32'd5);
        check("wr_readf", 32'(cap_rd), 32'd0);
        check("wr_wdata", 32'(cap_wd), 32'h7F);
        check("wr_ack_lat", 32'(ack0_rise_cyc - sack_fall_cyc), 32'd1);
        check("wr_c1_quiet", 32'(c1_ack_seen), 32'd0);
        check("wr_ret", 32'(ret0), 32'h7F);

        // Single read from c1.
        x1 = 32'd3; y1 = 32'd5; rd1 = 1'b1; wd1 = 8'h00;
        srv_ret = 8'h7F;
        rem1 = 1;
        wait_done("rd_done");
        check("rd_readf", 32'(cap_rd), 32'd1);
        check("rd_ret", 32'(ret1), 32'h7F);
        check("rd_busy_lat", 32'(busy_fall_cyc - c1_req_fall_cyc), 32'd1);

        // Simultaneous first requests after reset: c0 then c1.
        do_reset();
        order.delete(); rise_x.delete(); unstable = 0;
        x0 = 32'd10; x1 = 32'd20; rd0 = 1'b1; rd1 = 1'b1;
        srv_wait = 3; srv_ret = 8'h11;
        rem0 = 1; rem1 = 1;
        wait_done("tie_done");
        check("tie_count", 32'(order.size()), 32'd2);
        check("tie_first", 32'(order[0]), 32'd0);
        check("tie_second", 32'(order[1]), 32'd1);
        check("tie_x0", rise_x[0], 32'd10);
        check("tie_x1", rise_x[1], 32'd20);
        check("tie_stable", 32'(unstable), 32'd0);

        // Continuous requests from both: 10 alternating grants.
        order.delete(); rise_q.delete(); unstable = 0;
        srv_wait = 2;
        rem0 = 5; rem1 = 5;
        wait_done("alt_done");
        check("alt_pulses", 32'(rise_q.size()), 32'd10);
        check("alt_count", 32'(order.size()), 32'd10);
        alt_err = 0;
        foreach (order[i]) if (order[i] != (i % 2)) alt_err++;
        check("alt_order", 32'(alt_err), 32'd0);
        check("alt_stable", 32'(unstable), 32'd0);

        // Zero-wait turnaround, single client.
        rise_q.delete();
        srv_wait = 2;
        rem0 = 3;
        wait_done("turn_done");
        check("turn_pulses", 32'(rise_q.size()), 32'd3);
        check("turn_gap1", 32'(rise_q[1] - rise_q[0]), 32'd6);
        check("turn_gap2", 32'(rise_q[2] - rise_q[1]), 32'd6);

        // Reset while the server request is outstanding.
        x1 = 32'h33; srv_wait = 20;
        rem1 = 1;
        n = 0;
        while (!s_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_sreq_seen", 32'(s_req), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_s_req", 32'(s_req), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_s_x", s_x, 32'd0);
        check("mid_acks", 32'({c0_ack, c1_ack}), 32'd0);
        rem1 = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        order.delete();
        srv_wait = 3; srv_ret = 8'h5A;
        rem0 = 1; rem1 = 1;
        wait_done("post_tie_done");
        check("post_tie_first", 32'(order[0]), 32'd0);
        check("post_tie_second", 32'(order[1]), 32'd1);
        srv_ret = 8'hA5;
        rem1 = 1;
        wait_done("post_c1_done");
        check("post_c1_grant", 32'(order[2]), 32'd1);
        check("post_c1_ret", 32'(ret1), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
